// File: rtl/fir_decim_fmt.sv
// FIR output stage: decimate by DECIM, round/saturate IN_WIDTH -> OUT_WIDTH,
// then buffer in a first-word-fall-through FIFO with sticky sat/drop status.
module fir_decim_fmt #(
  parameter int IN_WIDTH   = 18,
  parameter int OUT_WIDTH  = 16,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk_main,
  input  logic                        rst_n,
  input  logic                        indata_vld,
  input  logic signed [IN_WIDTH-1:0]  data_in,
  input  logic                        phase_clr,
  output logic signed [OUT_WIDTH-1:0] data_out,
  output logic                        outdata_vld,
  input  logic                        outdata_rdy,
  output logic                        sat_flag,
  output logic                        drop_flag,
  output logic [15:0]                 drop_cnt,
  input  logic                        flag_clr
);

  localparam int SHIFT = IN_WIDTH - OUT_WIDTH;
  localparam int PW    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
  localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(FIFO_DEPTH);
  localparam logic signed [IN_WIDTH:0] RND  = {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [IN_WIDTH:0] OMAX = {{(SHIFT + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] OMIN = {{(SHIFT + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  // Valid/ready: the head transfers on a clock edge where outdata_vld & outdata_rdy;
  // outdata_vld only falls after such a transfer and data_out holds while stalled.

  logic [PW-1:0]  phase_q, phase_d, phase_base;
  logic           keep;

  logic signed [IN_WIDTH:0]    rnd_sum, rnd_shr;
  logic signed [OUT_WIDTH-1:0] rnd_val;
  logic                        rnd_sat;

  logic                        s1_vld_q;
  logic signed [OUT_WIDTH-1:0] s1_data_q;

  logic signed [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [AW:0]                 count_q, count_d;
  logic signed [OUT_WIDTH-1:0] last_q;
  logic                        pop, full, push, drop_ev, sat_ev;

  logic        sat_q, sat_d, drop_q, drop_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // phase_clr makes the current sample behave as phase 0
  always_comb begin
    phase_base = phase_clr ? '0 : phase_q;
    keep       = indata_vld && (phase_base == '0);
    phase_d    = phase_q;
    if (indata_vld) begin
      phase_d = (phase_base == PHASE_LAST) ? '0 : phase_base + 1'b1;
    end else if (phase_clr) begin
      phase_d = '0;
    end
  end

  // Round half toward +inf with one guard bit, then clamp to the output range
  always_comb begin
    rnd_sum = {data_in[IN_WIDTH-1], data_in} + RND;
    rnd_shr = rnd_sum >>> SHIFT;
    rnd_sat = 1'b0;
    rnd_val = rnd_shr[OUT_WIDTH-1:0];
    if (rnd_shr > OMAX) begin
      rnd_val = OMAX[OUT_WIDTH-1:0];
      rnd_sat = 1'b1;
    end else if (rnd_shr < OMIN) begin
      rnd_val = OMIN[OUT_WIDTH-1:0];
      rnd_sat = 1'b1;
    end
  end

  assign outdata_vld = (count_q != '0);
  assign data_out    = outdata_vld ? mem_q[rd_ptr_q] : last_q;
  assign pop         = outdata_vld && outdata_rdy;
  assign full        = (count_q == FULL_CNT);
  assign push        = s1_vld_q && (!full || pop);
  assign drop_ev     = s1_vld_q && full && !pop;
  assign sat_ev      = keep && rnd_sat;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A coincident event beats flag_clr
  always_comb begin
    sat_d      = sat_q | sat_ev;
    drop_d     = drop_q | drop_ev;
    drop_cnt_d = drop_cnt_q;
    if (flag_clr) begin
      sat_d      = sat_ev;
      drop_d     = drop_ev;
      drop_cnt_d = drop_ev ? 16'd1 : 16'd0;
    end else if (drop_ev && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= '0;
      s1_vld_q   <= 1'b0;
      s1_data_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= '0;
      sat_q      <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      phase_q    <= phase_d;
      s1_vld_q   <= keep;
      s1_data_q  <= rnd_val;
      count_q    <= count_d;
      sat_q      <= sat_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk_main) begin
    if (push) mem_q[wr_ptr_q] <= s1_data_q;
  end

  assign sat_flag  = sat_q;
  assign drop_flag = drop_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fir_decim_fmt.sv
// Bench for fir_decim_fmt: DECIM=1 and DECIM=4 instances share stimulus and are
// compared every cycle against a queue-based reference model.
module tb_fir_decim_fmt;

  localparam int DEPTH = 8;
  localparam int SHIFT = 2;
  localparam int OMAX  = 32767;
  localparam int OMIN  = -32768;

  logic        clk_main = 1'b0;
  logic        rst_n    = 1'b0;
  logic        indata_vld = 1'b0;
  logic [17:0] data_in  = '0;
  logic        phase_clr = 1'b0;
  logic        outdata_rdy = 1'b0;
  logic        flag_clr = 1'b0;

  logic signed [15:0] d1_data_out, d4_data_out;
  logic        d1_vld, d4_vld, d1_sat, d4_sat, d1_drop, d4_drop;
  logic [15:0] d1_cnt, d4_cnt;

  int checks = 0;
  int errors = 0;
  int din    = 0;

  int m_phase [2];
  bit m_s1v   [2];
  int m_s1d   [2];
  bit m_sat   [2];
  bit m_drop  [2];
  int m_dcnt  [2];
  int m_last  [2];
  int fq0[$];
  int fq1[$];
  int got[$];

  always #5 clk_main = ~clk_main;

  fir_decim_fmt #(.IN_WIDTH(18), .OUT_WIDTH(16), .DECIM(1), .FIFO_DEPTH(DEPTH)) u_d1 (
    .clk_main(clk_main), .rst_n(rst_n), .indata_vld(indata_vld), .data_in(data_in),
    .phase_clr(phase_clr), .data_out(d1_data_out), .outdata_vld(d1_vld),
    .outdata_rdy(outdata_rdy), .sat_flag(d1_sat), .drop_flag(d1_drop),
    .drop_cnt(d1_cnt), .flag_clr(flag_clr));

  fir_decim_fmt #(.IN_WIDTH(18), .OUT_WIDTH(16), .DECIM(4), .FIFO_DEPTH(DEPTH)) u_d4 (
    .clk_main(clk_main), .rst_n(rst_n), .indata_vld(indata_vld), .data_in(data_in),
    .phase_clr(phase_clr), .data_out(d4_data_out), .outdata_vld(d4_vld),
    .outdata_rdy(outdata_rdy), .sat_flag(d4_sat), .drop_flag(d4_drop),
    .drop_cnt(d4_cnt), .flag_clr(flag_clr));

  function automatic int dec_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic int q_size(input int k);
    return (k == 0) ? fq0.size() : fq1.size();
  endfunction

  function automatic int q_head(input int k);
    return (k == 0) ? fq0[0] : fq1[0];
  endfunction

  task automatic q_push(input int k, input int v);
    if (k == 0) fq0.push_back(v); else fq1.push_back(v);
  endtask

  task automatic q_pop(input int k);
    if (k == 0) void'(fq0.pop_front()); else void'(fq1.pop_front());
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_s1v[k] = 0; m_s1d[k] = 0;
      m_sat[k] = 0; m_drop[k] = 0; m_dcnt[k] = 0; m_last[k] = 0;
    end
    fq0.delete();
    fq1.delete();
  endtask

  // One clock edge of the reference, using the inputs held across that edge
  task automatic model_edge(input int k);
    int  sz, r;
    bit  pop, full, acc, drp, keep, sev;
    sz   = q_size(k);
    pop  = (sz > 0) && outdata_rdy;
    full = (sz == DEPTH);
    if (pop) begin
      m_last[k] = q_head(k);
      q_pop(k);
    end
    acc = m_s1v[k] && (!full || pop);
    drp = m_s1v[k] && full && !pop;
    if (acc) q_push(k, m_s1d[k]);
    keep = indata_vld && (phase_clr || m_phase[k] == 0);
    r    = (din + (1 << (SHIFT - 1))) >>> SHIFT;
    sev  = 0;
    if (r > OMAX) begin r = OMAX; sev = 1; end
    if (r < OMIN) begin r = OMIN; sev = 1; end
    m_s1v[k] = keep;
    m_s1d[k] = r;
    if (indata_vld) m_phase[k] = ((phase_clr ? 0 : m_phase[k]) + 1) % dec_of(k);
    else if (phase_clr) m_phase[k] = 0;
    if (flag_clr) begin
      m_sat[k]  = keep && sev;
      m_drop[k] = drp;
      m_dcnt[k] = drp ? 1 : 0;
    end else begin
      m_sat[k]  = m_sat[k] | (keep && sev);
      m_drop[k] = m_drop[k] | drp;
      if (drp && m_dcnt[k] < 65535) m_dcnt[k]++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic        ov, os, odr;
    logic [15:0] od, oc;
    int          e;
    string       p;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin ov = d1_vld; od = d1_data_out; os = d1_sat; odr = d1_drop; oc = d1_cnt; end
      else        begin ov = d4_vld; od = d4_data_out; os = d4_sat; odr = d4_drop; oc = d4_cnt; end
      p = $sformatf("dec%0d", dec_of(k));
      e = (q_size(k) > 0) ? q_head(k) : m_last[k];
      chk({p, "_vld"},  {31'b0, ov},  {31'b0, q_size(k) > 0});
      chk({p, "_data"}, {16'h0, od},  {16'h0, 16'(e)});
      chk({p, "_sat"},  {31'b0, os},  {31'b0, m_sat[k]});
      chk({p, "_drop"}, {31'b0, odr}, {31'b0, m_drop[k]});
      chk({p, "_cnt"},  {16'h0, oc},  {16'h0, 16'(m_dcnt[k])});
    end
  endtask

  task automatic step(input bit v, input int d, input bit c, input bit r, input bit f);
    indata_vld  = v;
    din         = d;
    data_in     = 18'(d);
    phase_clr   = c;
    outdata_rdy = r;
    flag_clr    = f;
    @(posedge clk_main);
    #1;
    model_edge(0);
    model_edge(1);
    check_all();
  endtask

  task automatic collect_d4();
    if (d4_vld && outdata_rdy) got.push_back(int'(d4_data_out));
  endtask

  task automatic check_got(input string tag, input int e0, input int e1, input int e2, input int e3);
    int exp_q[$];
    exp_q = '{e0, e1, e2, e3};
    chk({tag, "_count"}, got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk($sformatf("%s_%0d", tag, i), got[i], exp_q[i]);
    end
    got.delete();
  endtask

  initial begin
    int ext[5];
    ext = '{131071, 131070, 131069, -131072, -131071};

    // Reset state
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk_main);
    #3 rst_n = 1'b1;
    @(posedge clk_main);
    #1;

    // Rounding and saturation through the DECIM=1 path
    step(1, 5, 0, 1, 0);
    step(1, -6, 0, 1, 0);
    chk("t1_out0", {16'h0, d1_data_out}, 32'h0000_0001);
    step(1, 131071, 0, 1, 0);
    chk("t1_out1", {16'h0, d1_data_out}, 32'h0000_FFFF);
    step(1, -131072, 0, 1, 0);
    chk("t1_out2", {16'h0, d1_data_out}, 32'h0000_7FFF);
    chk("t1_sat",  {31'b0, d1_sat}, 32'd1);
    step(0, 0, 0, 1, 0);
    chk("t1_out3", {16'h0, d1_data_out}, 32'h0000_8000);
    step(0, 0, 0, 1, 1);

    // DECIM=4 continuous stream of 4*n
    for (int n = 0; n < 16; n++) begin
      step(1, 4 * n, 0, 1, 0);
      collect_d4();
    end
    repeat (3) begin step(0, 0, 0, 1, 0); collect_d4(); end
    check_got("t2_kept", 0, 4, 8, 12);

    // phase_clr on the n=2 sample
    for (int n = 0; n < 12; n++) begin
      step(1, 4 * n, (n == 2), 1, 0);
      collect_d4();
    end
    repeat (3) begin step(0, 0, 0, 1, 0); collect_d4(); end
    check_got("t3_clr", 0, 2, 6, 10);

    // Overflow with consumer stalled
    for (int n = 1; n <= 12; n++) step(1, 4 * n, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t4_drop_cnt",  {16'h0, d1_cnt}, 32'd4);
    chk("t4_drop_flag", {31'b0, d1_drop}, 32'd1);
    chk("t4_head",      {16'h0, d1_data_out}, 32'd1);
    // Write into a full FIFO on the same edge as a pop
    step(1, 4 * 13, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("t5_no_drop", {16'h0, d1_cnt}, 32'd4);
    repeat (3) step(0, 0, 0, 0, 0);
    repeat (12) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    chk("t4_clr_flag", {31'b0, d1_drop}, 32'd0);
    chk("t4_clr_cnt",  {16'h0, d1_cnt}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int d;
      if ($urandom_range(0, 9) == 0) d = ext[$urandom_range(0, 4)];
      else d = int'($urandom_range(0, 262143)) - 131072;
      step($urandom_range(0, 9) < 7, d, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
    end

    // Asynchronous reset mid-drain
    repeat (12) step(0, 0, 0, 1, 0);
    for (int n = 1; n <= 5; n++) step(1, 4 * n, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t6_filled", {31'b0, d1_vld}, 32'd1);
    outdata_rdy = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_vld",  {31'b0, d1_vld}, 32'd0);
    chk("t6_rst_data", {16'h0, d1_data_out}, 32'd0);
    chk("t6_rst_cnt",  {16'h0, d1_cnt}, 32'd0);
    check_all();
    #2 rst_n = 1'b1;
    step(1, 400, 0, 1, 0);
    chk("t6_lat1", {31'b0, d1_vld}, 32'd0);
    step(1, 404, 0, 1, 0);
    chk("t6_lat2_d1", {16'h0, d1_data_out}, 32'd100);
    chk("t6_lat2_d4", {16'h0, d4_data_out}, 32'd100);
    repeat (6) step(1, 420, 0, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_decim_fmt.md
Name: fir_decim_fmt

Overview:
Output stage directly downstream of fir_7dsp48. It takes the FIR's 18-bit output stream (data_out/outdata_vld), decimates it by DECIM, rounds and saturates each kept sample to OUT_WIDTH bits, and buffers the results in a first-word-fall-through FIFO behind a valid/ready handshake. It also keeps sticky saturation and drop status for the control interface.

Parameters:
IN_WIDTH, 18, input sample width (two's complement; matches FIR OUTDATA_WIDTH)
OUT_WIDTH, 16, output sample width; SHIFT = IN_WIDTH-OUT_WIDTH, must be >=1
DECIM, 4, decimation factor, >=1 (1 = pass every sample)
FIFO_DEPTH, 8, output FIFO entries, power of two, >=2

Ports:
clk_main  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
indata_vld  in  1  input sample valid (from FIR outdata_vld)
data_in  in  IN_WIDTH  signed input sample (from FIR data_out)
phase_clr  in  1  synchronous pulse: restart decimation phase at 0
data_out  out  OUT_WIDTH  signed output sample (FIFO head)
outdata_vld  out  1  FIFO non-empty
outdata_rdy  in  1  consumer ready; transfer when outdata_vld & outdata_rdy
sat_flag  out  1  sticky: some kept sample saturated
drop_flag  out  1  sticky: some kept sample lost to FIFO full
drop_cnt  out  16  count of dropped samples, saturates at 16'hFFFF
flag_clr  in  1  synchronous pulse: clear sat_flag, drop_flag, drop_cnt

Behaviour:
- Reset (rst_n low, async): phase=0, stage reg invalid, FIFO empty, outdata_vld=0, data_out=0, sat_flag=0, drop_flag=0, drop_cnt=0. Reset mid-stream discards all buffered and in-flight samples; no output until fresh input.
- Phase counter 0..DECIM-1, advances only on indata_vld, wraps DECIM-1 -> 0. Sample kept iff indata_vld and phase==0.
- phase_clr: next phase=0. If coincident with indata_vld, that sample is kept (treated as phase 0) and phase becomes 1 (0 if DECIM=1).
- Round/saturate (stage 1, registered on the edge the kept sample is sampled): r = (data_in + 2^(SHIFT-1)) >>> SHIFT, computed at IN_WIDTH+1 bits (round half toward +inf). If r > 2^(OUT_WIDTH-1)-1 -> clamp to max; if r < -2^(OUT_WIDTH-1) -> clamp to min; either clamp sets sat_flag.
- Stage 2: stage-1 result written to FIFO on the next edge. Latency: input sampled at edge k -> outdata_vld high and data_out valid after edge k+1 (FIFO empty case).
- FIFO: FWFT; data_out shows head whenever outdata_vld=1; data_out holds last popped value when empty (0 after reset). Pop on outdata_vld & outdata_rdy.
- Full: write accepted if a pop occurs the same cycle; otherwise sample dropped, drop_flag=1, drop_cnt+1 (saturating). Dropped samples do not disturb phase.
- Empty with simultaneous write and rdy: no bypass; written data appears next cycle.
- outdata_vld must not deassert without a pop; data_out stable while outdata_vld & !outdata_rdy.
- flag_clr coincident with a new saturation/drop event: event wins (flag=1, drop_cnt=1 for drop).
- indata_vld may be continuous (one sample per clock); full throughput sustained when outdata_rdy=1.

Test Plan:
- Reset then drive data_in = 5, -6, 131071, -131072 with DECIM=1, rdy=1 -> outputs 1, -1, 32767 (sat_flag=1), -32768 (no extra sat), each 2 edges after input.
- DECIM=4, continuous indata_vld, data_in = 4*n for n=0..15 -> outputs 0,4,8,12 (kept n=0,4,8,12), outdata_vld one cycle in four.
- Pulse phase_clr with the sample at n=2 in a DECIM=4 stream of 4*n -> outputs 0, 2, 6, 10, ...; kept on clr cycle and every 4th after.
- outdata_rdy=0, DECIM=1, push 12 samples 1..12 -> 8 held, drop_cnt=4, drop_flag=1; then rdy=1 -> drains 1..8 in order, data stable while stalled; flag_clr -> flags/count 0.
- Full FIFO with rdy pulsed the same cycle a sample arrives -> sample accepted, no drop, drop_cnt unchanged.
- Assert rst_n low asynchronously mid-drain with 5 entries buffered -> outdata_vld drops immediately, data_out=0, flags cleared; next input appears after 2 edges with phase restarted at 0.
